seg_scan_controller: RTL and testbench

Time-multiplexed scan controller that shares one four-bit-in, seven-segment-out decoder between four display digits. It holds a double-buffered set of four BCD/hex nibbles and drives the shared decoder's inputs and the active-low digit anodes. Each digit slot starts with a blanking interval to suppress ghosting. Writes land in a shadow buffer and become visible only at a frame boundary, so the display never tears.

---
 rtl/seg_scan_controller_if.sv | 22 ++
 rtl/seg_scan_controller.sv | 117 +++++++++++
 tb/tb_seg_scan_controller.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_controller_if.sv
// rtl/seg_scan_controller_if.sv - scan enable, shadow write, commit and display outputs
interface seg_scan_controller_if;
   logic       en;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [3:0] wr_data;
   logic       commit;
   logic [3:0] nibble;
   logic [3:0] an;
   logic       pending;
   logic       frame_start;

   modport master (
      output en, wr_en, wr_addr, wr_data, commit,
      input  nibble, an, pending, frame_start
   );

   modport slave (
      input  en, wr_en, wr_addr, wr_data, commit,
      output nibble, an, pending, frame_start
   );
endinterface

// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - four-digit multiplexed display scanner with double-buffered nibbles
module seg_scan_controller #(
   parameter int DWELL = 1000,
   parameter int BLANK = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   seg_scan_controller_if.slave  bus
);
   localparam int            CW        = $clog2(DWELL);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0]    idx, idx_n;
   logic [3:0]    shadow [4];
   logic [3:0]    active [4];
   logic          pending, pending_n;
   logic [3:0]    an, an_n;
   logic [3:0]    nibble, nibble_n;
   logic          frame_start, frame_start_n;
   logic          slot_end, frame_end, apply;

   // Next slot position, phase, and the registered output values that go with it
   always_comb begin
      cnt_n         = cnt;
      idx_n         = idx;
      state_n       = state;
      slot_end      = bus.en && (cnt == CNT_LAST);
      frame_end     = slot_end && (idx == 2'd3);
      apply         = frame_end && (pending || bus.commit);
      an_n          = 4'hF;
      nibble_n      = nibble;
      pending_n     = pending;
      frame_start_n = frame_end;

      if (bus.en) begin
         if (slot_end) begin
            cnt_n = '0;
            idx_n = idx + 2'd1;
         end else begin
            cnt_n = cnt + CNT_ONE;
         end
         state_n = (cnt_n < CNT_BLANK) ? ST_BLANK : ST_SHOW;
         if (state_n == ST_SHOW) begin
            an_n = ~(4'b0001 << idx_n);
         end
      end

      // Nibble only moves at a slot boundary, where the next cycle is always blank
      if (slot_end) begin
         nibble_n = apply ? shadow[0] : active[idx_n];
      end

      if (apply) begin
         pending_n = 1'b0;
      end else if (bus.commit) begin
         pending_n = 1'b1;
      end
   end

   // Scan position and phase; frozen while en is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_BLANK;
         cnt   <= '0;
         idx   <= 2'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
      end
   end

   // Registered display outputs and commit tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an          <= 4'hF;
         nibble      <= 4'h0;
         pending     <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         an          <= an_n;
         nibble      <= nibble_n;
         pending     <= pending_n;
         frame_start <= frame_start_n;
      end
   end

   // Shadow takes writes at any time; active copies the pre-edge shadow at an applying frame boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            shadow[i] <= 4'h0;
            active[i] <= 4'h0;
         end
      end else begin
         if (bus.wr_en) begin
            shadow[bus.wr_addr] <= bus.wr_data;
         end
         if (apply) begin
            for (int i = 0; i < 4; i++) begin
               active[i] <= shadow[i];
            end
         end
      end
   end

   assign bus.an          = an;
   assign bus.nibble      = nibble;
   assign bus.pending     = pending;
   assign bus.frame_start = frame_start;
endmodule

// File: tb/tb_seg_scan_controller.sv
// tb/tb_seg_scan_controller.sv - randomized and directed bench for seg_scan_controller
module tb_seg_scan_controller;
   localparam int DWELL = 8;
   localparam int BLANK = 2;
   localparam int FRAME = 4 * DWELL;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   seg_scan_controller_if bus ();

   seg_scan_controller #(.DWELL(DWELL), .BLANK(BLANK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference: display position is the count of enabled cycles since reset
   logic [3:0] m_shadow [4];
   logic [3:0] m_active [4];
   logic       m_pending;
   logic       m_fs;
   logic       m_last_en;
   int         m_pos;

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         m_shadow[i] = 4'h0;
         m_active[i] = 4'h0;
      end
      m_pending = 1'b0;
      m_fs      = 1'b0;
      m_last_en = 1'b1;
      m_pos     = 0;
   endfunction

   function automatic void model_edge();
      logic applied;
      applied = 1'b0;
      m_fs    = 1'b0;
      if (bus.en) begin
         m_pos++;
         if (m_pos % FRAME == 0) begin
            m_fs    = 1'b1;
            applied = m_pending || bus.commit;
            if (applied) begin
               for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
            end
         end
      end
      if (applied) m_pending = 1'b0;
      else if (bus.commit) m_pending = 1'b1;
      if (bus.wr_en) m_shadow[bus.wr_addr] = bus.wr_data;
      m_last_en = bus.en;
   endfunction

   function automatic logic [3:0] exp_an();
      logic [3:0] one;
      int off, d;
      one = 4'b0001;
      off = m_pos % DWELL;
      d   = (m_pos / DWELL) % 4;
      if (m_last_en && off >= BLANK) return ~(one << d);
      return 4'hF;
   endfunction

   function automatic logic [3:0] exp_nibble();
      return m_active[(m_pos / DWELL) % 4];
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      bus.wr_en  = 1'b0;
      bus.commit = 1'b0;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      bus.en      = 1'b1;
      bus.wr_en   = 1'b0;
      bus.wr_addr = 2'd0;
      bus.wr_data = 4'h0;
      bus.commit  = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.en = 1'b1; bus.wr_en = 1'b0; bus.commit = 1'b0;
      bus.wr_addr = 2'd0; bus.wr_data = 4'h0;
      #2 rst_n = 1'b0;
      #1;
      if (bus.an !== 4'hF) begin miscompares++; $display("FAIL reset_an got %b want 1111", bus.an); end
      vectors++;
      if (bus.nibble !== 4'h0) begin miscompares++; $display("FAIL reset_nibble got %h want 0", bus.nibble); end
      vectors++;
      if (bus.pending !== 1'b0) begin miscompares++; $display("FAIL reset_pending got %b want 0", bus.pending); end
      vectors++;
      if (bus.frame_start !== 1'b0) begin miscompares++; $display("FAIL reset_frame_start got %b want 0", bus.frame_start); end
      vectors++;
   endtask

   task automatic test_scan();
      logic fs_want;
      do_reset();
      for (int n = 1; n <= 72; n++) begin
         tick();
         if (bus.an !== exp_an()) begin miscompares++; $display("FAIL scan_an cycle %0d got %b want %b", n, bus.an, exp_an()); end
         vectors++;
         fs_want = (n == 32 || n == 64);
         if (bus.frame_start !== fs_want) begin miscompares++; $display("FAIL scan_frame_start cycle %0d got %b want %b", n, bus.frame_start, fs_want); end
         vectors++;
         if (n == 2 && bus.an !== 4'b1110) begin miscompares++; $display("FAIL scan_d0_show got %b want 1110", bus.an); end
         if (n == 9 && bus.an !== 4'b1111) begin miscompares++; $display("FAIL scan_d1_blank got %b want 1111", bus.an); end
         if (n == 10 && bus.an !== 4'b1101) begin miscompares++; $display("FAIL scan_d1_show got %b want 1101", bus.an); end
         if (n == 2 || n == 9 || n == 10) vectors++;
      end
   endtask

   task automatic test_write_commit();
      do_reset();
      for (int n = 0; n <= 56; n++) begin
         if (n == 2) begin bus.wr_en = 1'b1; bus.wr_addr = 2'd2; bus.wr_data = 4'h5; end
         if (n == 4) begin bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 4'h9; end
         if (n == 10) bus.commit = 1'b1;
         tick();
         if (bus.an !== exp_an() || bus.nibble !== exp_nibble() || bus.pending !== m_pending || bus.frame_start !== m_fs) begin
            miscompares++;
            $display("FAIL wc_model cycle %0d got an=%b nib=%h pend=%b fs=%b want an=%b nib=%h pend=%b fs=%b",
                     n + 1, bus.an, bus.nibble, bus.pending, bus.frame_start, exp_an(), exp_nibble(), m_pending, m_fs);
         end
         vectors++;
         if (n + 1 >= 11 && n + 1 <= 31) begin
            if (bus.pending !== 1'b1) begin miscompares++; $display("FAIL wc_pending cycle %0d got %b want 1", n + 1, bus.pending); end
            vectors++;
         end
         if (n + 1 == 32) begin
            if (bus.pending !== 1'b0 || bus.nibble !== 4'h9) begin
               miscompares++; $display("FAIL wc_apply got pend=%b nib=%h want pend=0 nib=9", bus.pending, bus.nibble);
            end
            vectors++;
         end
         if (n + 1 >= 48 && n + 1 <= 55) begin
            if (bus.nibble !== 4'h5) begin miscompares++; $display("FAIL wc_digit2 cycle %0d got %h want 5", n + 1, bus.nibble); end
            vectors++;
         end
      end
   endtask

   task automatic test_boundary_commit();
      int guard;
      bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 4'h3;
      tick();
      guard = 0;
      while (m_pos % FRAME != FRAME - 1 && guard < 80) begin tick(); guard++; end
      if (guard >= 80) begin miscompares++; $display("FAIL bnd_reach timeout got %0d want <80", guard); end
      vectors++;
      bus.commit = 1'b1;
      bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 4'hA;
      tick();
      if (bus.pending !== 1'b0 || bus.nibble !== 4'h3 || bus.frame_start !== 1'b1) begin
         miscompares++; $display("FAIL bnd_apply got pend=%b nib=%h fs=%b want pend=0 nib=3 fs=1", bus.pending, bus.nibble, bus.frame_start);
      end
      vectors++;
      for (int k = 0; k < FRAME; k++) begin
         tick();
         if (bus.an !== exp_an() || bus.nibble !== exp_nibble()) begin
            miscompares++; $display("FAIL bnd_model got an=%b nib=%h want an=%b nib=%h", bus.an, bus.nibble, exp_an(), exp_nibble());
         end
         vectors++;
      end
      if (bus.nibble !== 4'h3) begin miscompares++; $display("FAIL bnd_no_commit got %h want 3", bus.nibble); end
      vectors++;
      bus.commit = 1'b1;
      tick();
      guard = 0;
      while (m_pos % FRAME != 0 && guard < 80) begin tick(); guard++; end
      if (bus.nibble !== 4'hA || guard >= 80) begin
         miscompares++; $display("FAIL bnd_second_commit got nib=%h guard=%0d want nib=a", bus.nibble, guard);
      end
      vectors++;
   endtask

   task automatic test_freeze();
      do_reset();
      repeat (12) tick();
      bus.en = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (k == 5) bus.commit = 1'b1;
         tick();
         if (bus.an !== 4'hF || bus.frame_start !== 1'b0) begin
            miscompares++; $display("FAIL frz_blank k=%0d got an=%b fs=%b want an=1111 fs=0", k, bus.an, bus.frame_start);
         end
         vectors++;
         if (k >= 5) begin
            if (bus.pending !== 1'b1) begin miscompares++; $display("FAIL frz_pending k=%0d got %b want 1", k, bus.pending); end
            vectors++;
         end
      end
      bus.en = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (bus.an !== exp_an() || bus.pending !== m_pending || bus.frame_start !== m_fs) begin
            miscompares++; $display("FAIL frz_model k=%0d got an=%b pend=%b fs=%b want an=%b pend=%b fs=%b",
                                    k, bus.an, bus.pending, bus.frame_start, exp_an(), m_pending, m_fs);
         end
         vectors++;
         if (k <= 3 && bus.an !== 4'b1101) begin miscompares++; $display("FAIL frz_resume k=%0d got %b want 1101", k, bus.an); end
         if (k == 4 && bus.an !== 4'b1111) begin miscompares++; $display("FAIL frz_d2_blank got %b want 1111", bus.an); end
         if (k == 6 && bus.an !== 4'b1011) begin miscompares++; $display("FAIL frz_d2_show got %b want 1011", bus.an); end
         if (k == 20 && (bus.pending !== 1'b0 || bus.frame_start !== 1'b1)) begin
            miscompares++; $display("FAIL frz_apply got pend=%b fs=%b want pend=0 fs=1", bus.pending, bus.frame_start);
         end
         if (k <= 4 || k == 6 || k == 20) vectors++;
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      bus.wr_en = 1'b1; bus.wr_addr = 2'd2; bus.wr_data = 4'h7;
      bus.commit = 1'b1;
      tick();
      while (m_pos < FRAME + 20) begin
         if (m_pos == FRAME + 8) bus.commit = 1'b1;
         tick();
      end
      if (bus.an !== 4'b1011 || bus.pending !== 1'b1 || bus.nibble !== 4'h7) begin
         miscompares++; $display("FAIL ar_setup got an=%b pend=%b nib=%h want an=1011 pend=1 nib=7", bus.an, bus.pending, bus.nibble);
      end
      vectors++;
      #3 rst_n = 1'b0;
      #1;
      if (bus.an !== 4'hF || bus.pending !== 1'b0 || bus.nibble !== 4'h0 || bus.frame_start !== 1'b0) begin
         miscompares++; $display("FAIL ar_clear got an=%b pend=%b nib=%h fs=%b want an=1111 pend=0 nib=0 fs=0",
                                 bus.an, bus.pending, bus.nibble, bus.frame_start);
      end
      vectors++;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int n = 1; n <= 24; n++) begin
         tick();
         if (bus.an !== exp_an() || bus.nibble !== exp_nibble() || bus.pending !== m_pending) begin
            miscompares++; $display("FAIL ar_restart cycle %0d got an=%b nib=%h pend=%b want an=%b nib=%h pend=%b",
                                    n, bus.an, bus.nibble, bus.pending, exp_an(), exp_nibble(), m_pending);
         end
         vectors++;
         if (n == 20 && bus.nibble !== 4'h0) begin miscompares++; $display("FAIL ar_active_cleared got %h want 0", bus.nibble); end
         if (n == 20) vectors++;
      end
   endtask

   task automatic test_random();
      logic [3:0] prev_an, prev_nib;
      do_reset();
      prev_an  = 4'hF;
      prev_nib = 4'h0;
      for (int n = 0; n < 450; n++) begin
         bus.en      = ($urandom_range(0, 9) != 0);
         bus.wr_en   = ($urandom_range(0, 1) == 1);
         bus.wr_addr = 2'($urandom_range(0, 3));
         bus.wr_data = 4'($urandom_range(0, 15));
         bus.commit  = ($urandom_range(0, 19) == 0);
         tick();
         if (bus.an !== exp_an() || bus.nibble !== exp_nibble() || bus.pending !== m_pending || bus.frame_start !== m_fs) begin
            miscompares++;
            $display("FAIL rnd_model step %0d got an=%b nib=%h pend=%b fs=%b want an=%b nib=%h pend=%b fs=%b",
                     n, bus.an, bus.nibble, bus.pending, bus.frame_start, exp_an(), exp_nibble(), m_pending, m_fs);
         end
         vectors++;
         if (prev_an !== 4'hF && bus.an !== 4'hF && bus.nibble !== prev_nib) begin
            miscompares++; $display("FAIL rnd_nibble_while_lit step %0d got %h want %h", n, bus.nibble, prev_nib);
         end
         vectors++;
         prev_an  = bus.an;
         prev_nib = bus.nibble;
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_write_commit();
      test_boundary_commit();
      test_freeze();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog elapsed time %0t want finish before 500000", $time);
      $fatal(1);
   end
endmodule
